// File: rtl/vermibus_splitter.sv
// One-master, NUM_DEVICES-slave bus splitter: decodes m_address[31:24], forwards the handshake with zero added latency.
// Slow devices are waited on up to TIMEOUT_CYCLES; unmapped or timed-out accesses get ERROR_RDATA and are logged.
module vermibus_splitter #(
   parameter int                       NUM_DEVICES    = 4,
   parameter logic [NUM_DEVICES*8-1:0] DEV_ADDRESSES  = {8'h30, 8'h20, 8'h10, 8'h00},
   parameter int                       TIMEOUT_CYCLES = 16,
   parameter logic [31:0]              ERROR_RDATA    = 32'hDEADBEEF
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        m_valid,
   output logic                        m_ready,
   input  logic [31:0]                 m_address,
   input  logic [3:0]                  m_wstrobe,
   input  logic [31:0]                 m_wdata,
   output logic [31:0]                 m_rdata,
   output logic                        m_irq,
   output logic [NUM_DEVICES-1:0]      d_valid,
   output logic [31:0]                 d_address,
   output logic [3:0]                  d_wstrobe,
   output logic [31:0]                 d_wdata,
   input  logic [NUM_DEVICES-1:0]      d_ready,
   input  logic [NUM_DEVICES-1:0]      d_irq,
   input  logic [32*NUM_DEVICES-1:0]   d_rdata,
   input  logic [NUM_DEVICES-1:0]      irq_mask,
   input  logic                        err_clear,
   output logic [15:0]                 err_count,
   output logic [31:0]                 err_address
);

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

   state_t      state, state_nx;
   logic [7:0]  cnt, cnt_nx;
   logic [2:0]  idx, idx_nx, sel, tgt;
   logic        hit, tgt_ready, timeout, err_rec, drive_dv;
   logic [31:0] tgt_rdata;

   assign d_address = m_address;
   assign d_wstrobe = m_wstrobe;
   assign d_wdata   = m_wdata;
   assign m_irq     = |(d_irq & irq_mask);

   // Scan downwards so the lowest matching index is the one left standing.
   always_comb begin
      hit = 1'b0;
      sel = '0;
      for (int i = NUM_DEVICES - 1; i >= 0; i--) begin
         if (m_address[31:24] == DEV_ADDRESSES[8*i +: 8]) begin
            hit = 1'b1;
            sel = 3'(i);
         end
      end
   end

   always_comb begin
      tgt       = (state == ST_WAIT) ? idx : sel;
      tgt_ready = 1'b0;
      tgt_rdata = '0;
      for (int i = 0; i < NUM_DEVICES; i++) begin
         if (tgt == 3'(i)) begin
            tgt_ready = d_ready[i];
            tgt_rdata = d_rdata[32*i +: 32];
         end
      end
      timeout = (state == ST_WAIT) && !tgt_ready && (cnt >= TMO);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         idx         <= '0;
         err_count   <= '0;
         err_address <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         idx   <= idx_nx;
         if (err_rec) begin
            err_address <= m_address;
            if (err_clear)
               err_count <= 16'd1;
            else if (err_count != 16'hFFFF)
               err_count <= err_count + 16'd1;
         end else if (err_clear) begin
            err_count <= '0;
         end
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      idx_nx   = idx;
      err_rec  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (m_valid) begin
               if (!hit) begin
                  err_rec = 1'b1;
               end else if (!tgt_ready) begin
                  state_nx = ST_WAIT;
                  cnt_nx   = 8'd1;
                  idx_nx   = sel;
               end
            end
         end
         ST_WAIT: begin
            if (tgt_ready) begin
               state_nx = ST_IDLE;
               cnt_nx   = '0;
            end else if (timeout) begin
               state_nx = ST_IDLE;
               cnt_nx   = '0;
               err_rec  = 1'b1;
            end else begin
               cnt_nx = cnt + 8'd1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      d_valid  = '0;
      m_ready  = 1'b0;
      m_rdata  = '0;
      drive_dv = 1'b0;
      case (state)
         ST_IDLE: begin
            if (m_valid && hit) begin
               drive_dv = 1'b1;
               m_ready  = tgt_ready;
               m_rdata  = tgt_rdata;
            end else if (m_valid) begin
               m_ready = 1'b1;
               m_rdata = ERROR_RDATA;
            end
         end
         ST_WAIT: begin
            if (timeout) begin
               m_ready = 1'b1;
               m_rdata = ERROR_RDATA;
            end else begin
               drive_dv = 1'b1;
               m_ready  = tgt_ready;
               m_rdata  = tgt_rdata;
            end
         end
         default: ;
      endcase
      for (int i = 0; i < NUM_DEVICES; i++)
         if (drive_dv && tgt == 3'(i)) d_valid[i] = 1'b1;
      if (!m_valid) begin
         m_ready = 1'b0;
         m_rdata = '0;
      end
      // Reset must drop the request at once, even while the master still holds m_valid.
      if (!reset) begin
         d_valid = '0;
         m_ready = 1'b0;
         m_rdata = '0;
      end
   end

endmodule

// File: tb/tb_vermibus_splitter.sv
// Bench for vermibus_splitter: vector table, directed multi-cycle sequences, then random traffic vs a transaction model.
module tb_vermibus_splitter;

   logic         clk = 1'b0;
   logic         reset;
   logic         m_valid, m_ready, m_irq, err_clear;
   logic [31:0]  m_address, m_wdata, m_rdata, d_address, d_wdata, err_address;
   logic [3:0]   m_wstrobe, d_wstrobe, d_valid, d_ready, d_irq, irq_mask;
   logic [127:0] d_rdata;
   logic [15:0]  err_count;

   int total = 0;
   int bad   = 0;

   logic [7:0] codes [4] = '{8'h00, 8'h10, 8'h20, 8'h30};

   typedef struct packed {
      logic        v;
      logic [31:0] a;
      logic [3:0]  rdy;
      logic [3:0]  irq;
      logic [3:0]  mask;
      logic        erdy;
      logic [31:0] erd;
      logic [3:0]  edv;
      logic        eirq;
   } vec_t;

   vec_t vecs [8];

   vermibus_splitter dut (
      .clk(clk), .reset(reset),
      .m_valid(m_valid), .m_ready(m_ready), .m_address(m_address),
      .m_wstrobe(m_wstrobe), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_irq(m_irq),
      .d_valid(d_valid), .d_address(d_address), .d_wstrobe(d_wstrobe), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_irq(d_irq), .d_rdata(d_rdata), .irq_mask(irq_mask),
      .err_clear(err_clear), .err_count(err_count), .err_address(err_address)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h want %08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rd_pat(input int i);
      return 32'hA000_0000 | 32'(i);
   endfunction

   function automatic int decode(input logic [7:0] s);
      for (int i = 0; i < 4; i++)
         if (s == codes[i]) return i;
      return -1;
   endfunction

   task automatic do_reset();
      reset = 1'b0;
      tick();
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   initial begin
      int t, pidx, age, kk, ecnt;
      bit busy, pend, e_rdy, e_err;
      logic [31:0] e_rd, eaddr;
      logic [3:0]  e_dv;
      logic [7:0]  s;

      vecs[0] = '{1'b0, 32'h1000_0004, 4'hF, 4'hF, 4'h0, 1'b0, 32'h0,         4'h0, 1'b0};
      vecs[1] = '{1'b1, 32'h1000_0004, 4'h2, 4'h5, 4'h4, 1'b1, 32'hA000_0001, 4'h2, 1'b1};
      vecs[2] = '{1'b1, 32'h00AB_CDEF, 4'h1, 4'h0, 4'hF, 1'b1, 32'hA000_0000, 4'h1, 1'b0};
      vecs[3] = '{1'b1, 32'h3000_0000, 4'h8, 4'h8, 4'h7, 1'b1, 32'hA000_0003, 4'h8, 1'b0};
      vecs[4] = '{1'b1, 32'h20FF_FFFF, 4'hF, 4'hA, 4'hA, 1'b1, 32'hA000_0002, 4'h4, 1'b1};
      vecs[5] = '{1'b1, 32'h7F00_0000, 4'hF, 4'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 4'h0, 1'b0};
      vecs[6] = '{1'b1, 32'h3100_0000, 4'h0, 4'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 4'h0, 1'b0};
      vecs[7] = '{1'b0, 32'h7F00_0000, 4'h0, 4'h0, 4'h0, 1'b0, 32'h0,         4'h0, 1'b0};

      reset = 1'b0; m_valid = 1'b0; m_address = '0; m_wstrobe = '0; m_wdata = '0;
      d_ready = '0; d_irq = '0; irq_mask = '0; err_clear = 1'b0;
      for (int i = 0; i < 4; i++) d_rdata[32*i +: 32] = rd_pat(i);
      tick();
      chk("rst_err_count", 32'(err_count), 32'h0);
      chk("rst_err_address", err_address, 32'h0);
      chk("rst_d_valid", 32'(d_valid), 32'h0);
      chk("rst_m_ready", 32'(m_ready), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      tick();

      foreach (vecs[k]) begin
         m_valid = vecs[k].v; m_address = vecs[k].a; d_ready = vecs[k].rdy;
         d_irq = vecs[k].irq; irq_mask = vecs[k].mask;
         m_wstrobe = 4'(k + 3); m_wdata = 32'h5A5A_0000 + 32'(k);
         #1;
         chk($sformatf("vec%0d_m_ready", k), 32'(m_ready), 32'(vecs[k].erdy));
         chk($sformatf("vec%0d_m_rdata", k), m_rdata, vecs[k].erd);
         chk($sformatf("vec%0d_d_valid", k), 32'(d_valid), 32'(vecs[k].edv));
         chk($sformatf("vec%0d_m_irq", k), 32'(m_irq), 32'(vecs[k].eirq));
         chk($sformatf("vec%0d_d_wdata", k), d_wdata, 32'h5A5A_0000 + 32'(k));
         chk($sformatf("vec%0d_d_wstrobe", k), 32'(d_wstrobe), 32'(k + 3));
         tick();
      end
      chk("tbl_err_count", 32'(err_count), 32'd2);
      chk("tbl_err_address", err_address, 32'h3100_0000);

      // plain clear
      m_valid = 1'b0; err_clear = 1'b1; tick(); err_clear = 1'b0;
      chk("clear_err_count", 32'(err_count), 32'd0);

      // device 2 ready three cycles after valid
      m_valid = 1'b1; m_address = 32'h2000_0040;
      for (int c = 0; c <= 3; c++) begin
         d_ready = (c == 3) ? 4'b0100 : 4'b0000;
         #1;
         chk($sformatf("slow_d_valid_c%0d", c), 32'(d_valid), 32'h4);
         chk($sformatf("slow_m_ready_c%0d", c), 32'(m_ready), 32'(c == 3));
         if (c == 3) chk("slow_m_rdata", m_rdata, rd_pat(2));
         tick();
      end
      m_valid = 1'b0; d_ready = '0; #1;
      chk("slow_after_d_valid", 32'(d_valid), 32'h0);
      chk("slow_err_count", 32'(err_count), 32'd0);

      // device 0 never ready: timeout on cycle 16
      m_valid = 1'b1; m_address = 32'h0000_0010;
      for (int c = 0; c <= 16; c++) begin
         #1;
         chk($sformatf("tmo_d_valid_c%0d", c), 32'(d_valid), (c < 16) ? 32'h1 : 32'h0);
         chk($sformatf("tmo_m_ready_c%0d", c), 32'(m_ready), 32'(c == 16));
         if (c == 16) chk("tmo_m_rdata", m_rdata, 32'hDEAD_BEEF);
         tick();
      end
      m_valid = 1'b0; #1;
      chk("tmo_err_count", 32'(err_count), 32'd1);
      chk("tmo_err_address", err_address, 32'h0000_0010);

      // ready arriving on the timeout cycle wins
      m_valid = 1'b1; m_address = 32'h0000_0020;
      for (int c = 0; c <= 16; c++) begin
         d_ready = (c == 16) ? 4'b0001 : 4'b0000;
         #1;
         if (c == 16) begin
            chk("prio_m_ready", 32'(m_ready), 32'h1);
            chk("prio_m_rdata", m_rdata, rd_pat(0));
            chk("prio_d_valid", 32'(d_valid), 32'h1);
         end
         tick();
      end
      m_valid = 1'b0; d_ready = '0; #1;
      chk("prio_err_count", 32'(err_count), 32'd1);

      // unmapped access
      m_valid = 1'b1; m_address = 32'h7F00_0000; #1;
      chk("unm_m_ready", 32'(m_ready), 32'h1);
      chk("unm_m_rdata", m_rdata, 32'hDEAD_BEEF);
      chk("unm_d_valid", 32'(d_valid), 32'h0);
      tick();
      m_valid = 1'b0; #1;
      chk("unm_err_address", err_address, 32'h7F00_0000);
      chk("unm_err_count", 32'(err_count), 32'd2);

      // clear coinciding with an error while count is 5
      for (int c = 0; c < 3; c++) begin
         m_valid = 1'b1; m_address = 32'h4000_0000 + 32'(c); tick();
      end
      m_valid = 1'b0; #1;
      chk("five_err_count", 32'(err_count), 32'd5);
      m_valid = 1'b1; m_address = 32'h5500_0000; err_clear = 1'b1; tick();
      m_valid = 1'b0; err_clear = 1'b0; #1;
      chk("clrerr_err_count", 32'(err_count), 32'd1);
      chk("clrerr_err_address", err_address, 32'h5500_0000);

      // reset during WAIT
      m_valid = 1'b1; m_address = 32'h3000_0000; d_ready = '0;
      tick(); tick();
      chk("rstw_pre_d_valid", 32'(d_valid), 32'h8);
      reset = 1'b0; #1;
      chk("rstw_d_valid", 32'(d_valid), 32'h0);
      chk("rstw_m_ready", 32'(m_ready), 32'h0);
      chk("rstw_err_count", 32'(err_count), 32'd0);
      m_valid = 1'b0;
      tick();
      @(negedge clk);
      reset = 1'b1;
      tick();
      m_valid = 1'b1; m_address = 32'h1000_0000; d_ready = 4'b0010; #1;
      chk("rstw_next_m_ready", 32'(m_ready), 32'h1);
      chk("rstw_next_d_valid", 32'(d_valid), 32'h2);
      chk("rstw_next_m_rdata", m_rdata, rd_pat(1));
      chk("rstw_next_err_count", 32'(err_count), 32'd0);
      tick();
      m_valid = 1'b0; d_ready = '0;

      // random traffic vs transaction model
      do_reset();
      busy = 1'b0; pend = 1'b0; age = 0; pidx = 0; kk = 1; ecnt = 0; eaddr = '0; t = 0;
      for (int c = 0; c < 3000; c++) begin
         if (!busy && $urandom_range(0, 9) < 7) begin
            busy = 1'b1;
            s = ($urandom_range(0, 3) != 0) ? codes[$urandom_range(0, 3)] : 8'($urandom);
            m_address = {s, 24'($urandom)};
            m_wstrobe = 4'($urandom); m_wdata = $urandom;
            case ($urandom_range(0, 2))
               0: kk = 1;
               1: kk = 3;
               default: kk = 20;
            endcase
         end
         m_valid = busy;
         for (int i = 0; i < 4; i++) d_ready[i] = ($urandom_range(0, kk - 1) == 0);
         d_rdata = {$urandom, $urandom, $urandom, $urandom};
         d_irq = 4'($urandom); irq_mask = 4'($urandom);
         err_clear = ($urandom_range(0, 39) == 0);
         #1;
         e_rdy = 1'b0; e_rd = '0; e_dv = '0; e_err = 1'b0;
         if (pend) begin
            if (d_ready[pidx]) begin
               e_rdy = 1'b1; e_rd = d_rdata[32*pidx +: 32]; e_dv[pidx] = 1'b1;
            end else if (age == 16) begin
               e_rdy = 1'b1; e_rd = 32'hDEAD_BEEF; e_err = 1'b1;
            end else begin
               e_dv[pidx] = 1'b1;
            end
         end else if (m_valid) begin
            t = decode(m_address[31:24]);
            if (t < 0) begin
               e_rdy = 1'b1; e_rd = 32'hDEAD_BEEF; e_err = 1'b1;
            end else begin
               e_dv[t] = 1'b1;
               if (d_ready[t]) begin
                  e_rdy = 1'b1; e_rd = d_rdata[32*t +: 32];
               end
            end
         end
         chk("rnd_d_valid", 32'(d_valid), 32'(e_dv));
         chk("rnd_m_ready", 32'(m_ready), 32'(e_rdy));
         if (e_rdy || !m_valid) chk("rnd_m_rdata", m_rdata, e_rd);
         chk("rnd_m_irq", 32'(m_irq), 32'(|(d_irq & irq_mask)));
         chk("rnd_d_address", d_address, m_address);
         chk("rnd_err_count", 32'(err_count), 32'(ecnt));
         chk("rnd_err_address", err_address, eaddr);
         if (e_err) begin
            eaddr = m_address;
            ecnt = err_clear ? 1 : ((ecnt < 65535) ? ecnt + 1 : ecnt);
         end else if (err_clear) begin
            ecnt = 0;
         end
         if (pend) begin
            if (e_rdy) pend = 1'b0;
            else age++;
         end else if (m_valid && !e_rdy) begin
            pend = 1'b1; pidx = t; age = 1;
         end
         if (e_rdy) busy = 1'b0;
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
